// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmitter and receiver: the frame-state
//   enumeration, the default frame width, the baud counter width and the
//   clamp that keeps the half bit period usable.
//
//   Contents:
//     uart_state_t       IDLE / START / DATA / STOP
//     DATA_BITS_DEFAULT  data bits per frame (8N1 framing)
//     MIN_HALF_PERIOD    smallest half bit period, in clock cycles
//     BAUD_COUNT_W       width of the baud counters
//     effective_half()   clamps a baud_division value to MIN_HALF_PERIOD
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DATA_BITS_DEFAULT = 8;
    localparam int MIN_HALF_PERIOD   = 2;
    localparam int BAUD_COUNT_W      = 9;

    // A half period below MIN_HALF_PERIOD leaves no room to find mid-bit
    // with a synchronised line, so 0 and 1 are treated as 2. The result is
    // one bit wider than the input so that the full bit period (twice this
    // value) still fits a baud counter.
    function automatic logic [BAUD_COUNT_W-1:0] effective_half(input logic [7:0] division);
        if (division < 8'(MIN_HALF_PERIOD)) begin
            return BAUD_COUNT_W'(MIN_HALF_PERIOD);
        end
        return {1'b0, division};
    endfunction

endpackage

// File: rtl/uart_receiver_sync_bit.sv
// sync_bit
//   Multi-flop synchroniser for one asynchronous input. Every stage presets
//   to 1, which suits idle-high lines: a pin that is already low when reset
//   releases reads as a steady low, never as a fresh falling edge.
//
//   Ports:
//     clock     in   destination clock
//     reset_n   in   asynchronous active-low reset (stages preset to 1)
//     async_in  in   asynchronous input pin
//     sync_out  out  input re-timed into the clock domain
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   Receive half of the UART link: 8N1 framing, LSB first, idle-high line.
//   The start bit is qualified at mid-bit, every data bit and the stop bit
//   are sampled at their centres, and each frame ends in either a one-cycle
//   rx_valid (good stop bit) or a one-cycle rx_frame_error (stop bit low).
//
//   Ports:
//     clock           in   main clock, rising edge
//     reset_n         in   asynchronous active-low reset
//     baud_division   in   half bit period in clocks (0/1 behave as 2)
//     uart_rx         in   serial line, asynchronous, idles high
//     rx_data         out  last correctly framed byte, held until the next one
//     rx_valid        out  one-cycle pulse when rx_data updates
//     rx_frame_error  out  one-cycle pulse when the stop bit reads low
//     rx_busy         out  high whenever a frame is in progress
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           baud_division,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_error,
    output logic                 rx_busy
);

    localparam int              INDEX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DATA_BITS - 1);

    logic                    rx_line;
    logic                    rx_prev;
    uart_state_t             state_q;
    uart_state_t             state_d;
    logic [BAUD_COUNT_W-1:0] count_q;
    logic [BAUD_COUNT_W-1:0] count_d;
    logic [BAUD_COUNT_W-1:0] half_period;
    logic [BAUD_COUNT_W-1:0] half_terminal;
    logic [BAUD_COUNT_W-1:0] bit_terminal;
    logic [INDEX_W-1:0]      index_q;
    logic [INDEX_W-1:0]      index_d;
    logic [DATA_BITS-1:0]    shift_q;
    logic [DATA_BITS-1:0]    shift_d;
    logic [DATA_BITS-1:0]    data_d;
    logic                    valid_d;
    logic                    error_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (uart_rx),
        .sync_out (rx_line)
    );

    // The half period never exceeds 255, so doubling it cannot overflow the
    // 9-bit counter.
    assign half_period   = effective_half(baud_division);
    assign half_terminal = half_period - BAUD_COUNT_W'(1);
    assign bit_terminal  = {half_period[BAUD_COUNT_W-2:0], 1'b0} - BAUD_COUNT_W'(1);

    assign rx_busy = (state_q != IDLE);

    // State, counters, shift register and the registered output strobes.
    // rx_prev presets high for the same reason the synchroniser does.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            index_q        <= '0;
            shift_q        <= '0;
            rx_prev        <= 1'b1;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            index_q        <= index_d;
            shift_q        <= shift_d;
            rx_prev        <= rx_line;
            rx_data        <= data_d;
            rx_valid       <= valid_d;
            rx_frame_error <= error_d;
        end
    end

    // The counter restarts from zero on every state change, so START waits
    // half a bit to land mid start bit and every later state waits a whole
    // bit to land mid-bit again. Leaving STOP at mid stop bit gives the next
    // start edge half a bit of slack even with zero idle time between frames.
    always_comb begin
        state_d = state_q;
        count_d = count_q + BAUD_COUNT_W'(1);
        index_d = index_q;
        shift_d = shift_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        error_d = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (rx_prev && !rx_line) begin
                    state_d = START;
                end
            end

            START: begin
                if (count_q == half_terminal) begin
                    count_d = '0;
                    if (!rx_line) begin
                        state_d = DATA;
                        index_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (count_q == bit_terminal) begin
                    count_d          = '0;
                    shift_d[index_q] = rx_line;
                    if (index_q == LAST_INDEX) begin
                        state_d = STOP;
                    end else begin
                        index_d = index_q + INDEX_W'(1);
                    end
                end
            end

            STOP: begin
                if (count_q == bit_terminal) begin
                    count_d = '0;
                    state_d = IDLE;
                    if (rx_line) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
